// File: rtl/data_memory_mmio.sv
// Word-addressed data RAM plus a memory-mapped peripheral page (LED, switches, cycle counter, down-timer).
// Optional unmapped-access capture (ERR_ADDR/ERR_STATUS) is built when DMEM_ERROR_CAPTURE_EN is defined.
module data_memory_mmio #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_write_value,
  input  logic        memory_write_enable,
  output logic [31:0] memory_read_value,
  input  logic [17:0] switches,
  output logic [17:0] ledr,
  output logic        timer_irq
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  localparam logic [13:0] OFF_LED    = 14'h0000;
  localparam logic [13:0] OFF_SW     = 14'h0001;
  localparam logic [13:0] OFF_CYCLES = 14'h0002;
  localparam logic [13:0] OFF_COUNT  = 14'h0003;
  localparam logic [13:0] OFF_STATUS = 14'h0004;

  logic             ram_hit;
  logic             mmio_hit;
  logic [13:0]      offset;
  logic [IDX_W-1:0] ram_idx;

  assign ram_hit  = memory_address < RAM_BYTES;
  assign mmio_hit = memory_address[31:16] == MMIO_BASE[31:16];
  assign offset   = memory_address[15:2];
  assign ram_idx  = memory_address[IDX_W+1:2];

  logic wr_led;
  logic wr_cycles;
  logic wr_count;
  logic wr_status;

  assign wr_led    = memory_write_enable && !ram_hit && mmio_hit && (offset == OFF_LED);
  assign wr_cycles = memory_write_enable && !ram_hit && mmio_hit && (offset == OFF_CYCLES);
  assign wr_count  = memory_write_enable && !ram_hit && mmio_hit && (offset == OFF_COUNT);
  assign wr_status = memory_write_enable && !ram_hit && mmio_hit && (offset == OFF_STATUS);

  // RAM: no reset, contents survive a processor reset
  logic [31:0] ram [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (memory_write_enable && ram_hit) ram[ram_idx] <= memory_write_value;
  end

  logic [17:0] led;
  logic [17:0] sw_p0;
  logic [17:0] sw_p1;
  logic [31:0] cycles;
  logic [31:0] count;
  logic        expired;
  logic        timer_fire;

  // Expiry only on a real 1->0 decrement; a load in the same cycle pre-empts it
  assign timer_fire = !wr_count && (count == 32'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      led     <= '0;
      sw_p0   <= '0;
      sw_p1   <= '0;
      cycles  <= '0;
      count   <= '0;
      expired <= 1'b0;
    end else begin
      sw_p0  <= switches;
      sw_p1  <= sw_p0;
      cycles <= wr_cycles ? 32'd0 : cycles + 32'd1;
      if (wr_led) led <= memory_write_value[17:0];
      if (wr_count) count <= memory_write_value;
      else if (count != 32'd0) count <= count - 32'd1;
      if (timer_fire) expired <= 1'b1;
      else if (wr_status && memory_write_value[0]) expired <= 1'b0;
    end
  end

`ifdef DMEM_ERROR_CAPTURE_EN
  localparam logic [13:0] OFF_ERR_ADDR   = 14'h0005;
  localparam logic [13:0] OFF_ERR_STATUS = 14'h0006;

  logic [31:0] err_addr;
  logic        err_valid;
  logic        unmapped;
  logic        wr_err_status;

  assign unmapped      = !ram_hit && !mmio_hit;
  assign wr_err_status = memory_write_enable && !ram_hit && mmio_hit && (offset == OFF_ERR_STATUS);

  always_ff @(posedge clock) begin
    if (reset) begin
      err_addr  <= '0;
      err_valid <= 1'b0;
    end else if (unmapped && !err_valid) begin
      err_addr  <= memory_address;
      err_valid <= 1'b1;
    end else if (wr_err_status && memory_write_value[0]) begin
      err_valid <= 1'b0;
    end
  end
`endif

  always_comb begin
    memory_read_value = '0;
    if (ram_hit) begin
      memory_read_value = ram[ram_idx];
    end else if (mmio_hit) begin
      case (offset)
        OFF_LED:        memory_read_value = {14'b0, led};
        OFF_SW:         memory_read_value = {14'b0, sw_p1};
        OFF_CYCLES:     memory_read_value = cycles;
        OFF_COUNT:      memory_read_value = count;
        OFF_STATUS:     memory_read_value = {31'b0, expired};
`ifdef DMEM_ERROR_CAPTURE_EN
        OFF_ERR_ADDR:   memory_read_value = err_addr;
        OFF_ERR_STATUS: memory_read_value = {31'b0, err_valid};
`endif
        default:        memory_read_value = '0;
      endcase
    end
  end

  assign ledr      = led;
  assign timer_irq = expired;

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed bench for data_memory_mmio: vector table for RAM/LED/decode, hand sequences for
// reset, switches, cycle counter, timer, mid-run reset and (when enabled) error capture.
module tb_data_memory_mmio;

  logic        clock;
  logic        reset;
  logic [31:0] memory_address;
  logic [31:0] memory_write_value;
  logic        memory_write_enable;
  logic [31:0] memory_read_value;
  logic [17:0] switches;
  logic [17:0] ledr;
  logic        timer_irq;

  data_memory_mmio dut (
    .clock               (clock),
    .reset               (reset),
    .memory_address      (memory_address),
    .memory_write_value  (memory_write_value),
    .memory_write_enable (memory_write_enable),
    .memory_read_value   (memory_read_value),
    .switches            (switches),
    .ledr                (ledr),
    .timer_irq           (timer_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        chk;
    logic [31:0] exp_rd;
    logic [17:0] exp_led;
  } vec_t;

  vec_t vecs[$];
  int   tests;
  int   fails;

  localparam logic [31:0] LED    = 32'hFFFF0000;
  localparam logic [31:0] SW     = 32'hFFFF0004;
  localparam logic [31:0] CYC    = 32'hFFFF0008;
  localparam logic [31:0] CNT    = 32'hFFFF000C;
  localparam logic [31:0] STAT   = 32'hFFFF0010;

  function automatic void add(input logic [31:0] a, input logic [31:0] d, input logic w,
                              input logic c, input logic [31:0] er, input logic [17:0] el);
    vecs.push_back('{addr: a, wdata: d, we: w, chk: c, exp_rd: er, exp_led: el});
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // One bus cycle: drive, sample at negedge (before the commit edge), then advance past posedge
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w, input logic c,
                      input logic [31:0] er, input logic [17:0] el, input logic ei, input string nm);
    memory_address      = a;
    memory_write_value  = d;
    memory_write_enable = w;
    @(negedge clock);
    if (c) check({nm, ".rd"}, memory_read_value, er);
    check({nm, ".ledr"}, {14'b0, ledr}, {14'b0, el});
    check({nm, ".irq"}, {31'b0, timer_irq}, {31'b0, ei});
    @(posedge clock);
    #1;
    memory_address      = 32'h0;
    memory_write_enable = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;

    add(32'h10,  32'h11111111, 1, 0, 32'h0,        18'h0);
    add(32'h10,  32'hDEADBEEF, 1, 1, 32'h11111111, 18'h0);
    add(32'h10,  32'h0,        0, 1, 32'hDEADBEEF, 18'h0);
    add(32'h13,  32'h0,        0, 1, 32'hDEADBEEF, 18'h0);
    add(32'h14,  32'hCAFEF00D, 1, 0, 32'h0,        18'h0);
    add(32'h14,  32'h0,        0, 1, 32'hCAFEF00D, 18'h0);
    add(32'h10,  32'h0,        0, 1, 32'hDEADBEEF, 18'h0);
    add(32'h0,   32'hA5A5A5A5, 1, 0, 32'h0,        18'h0);
    add(32'h3FC, 32'h0F0F0F0F, 1, 0, 32'h0,        18'h0);
    add(32'h3FC, 32'h0,        0, 1, 32'h0F0F0F0F, 18'h0);
    add(32'h400, 32'h12345678, 1, 1, 32'h0,        18'h0);
    add(32'h0,   32'h0,        0, 1, 32'hA5A5A5A5, 18'h0);
    add(32'h400, 32'h0,        0, 1, 32'h0,        18'h0);
    add(LED,     32'h0003FFFF, 1, 1, 32'h0,        18'h0);
    add(LED,     32'h0,        0, 1, 32'h0003FFFF, 18'h3FFFF);
    add(LED,     32'hFFFC0015, 1, 1, 32'h0003FFFF, 18'h3FFFF);
    add(LED,     32'h0,        0, 1, 32'h00000015, 18'h00015);
    add(LED,     32'h0003FFFF, 1, 1, 32'h00000015, 18'h00015);
    add(32'h00010000, 32'hFFFFFFFF, 1, 1, 32'h0, 18'h3FFFF);
    add(32'h00010000, 32'h0,        0, 1, 32'h0, 18'h3FFFF);
    add(32'hFFFE0000, 32'hFFFFFFFF, 1, 1, 32'h0, 18'h3FFFF);
    add(32'hFFFE0000, 32'h0,        0, 1, 32'h0, 18'h3FFFF);
    add(LED,     32'h0,        0, 1, 32'h0003FFFF, 18'h3FFFF);
    add(32'h0,   32'h0,        0, 1, 32'hA5A5A5A5, 18'h3FFFF);
    add(SW,      32'h0003FFFF, 1, 1, 32'h0,        18'h3FFFF);
    add(SW,      32'h0,        0, 1, 32'h0,        18'h3FFFF);
    add(32'hFFFF0040, 32'hFFFFFFFF, 1, 1, 32'h0,   18'h3FFFF);
    add(32'hFFFF0040, 32'h0,        0, 1, 32'h0,   18'h3FFFF);
    add(32'h10,  32'h0,        0, 1, 32'hDEADBEEF, 18'h3FFFF);

    reset               = 1'b1;
    memory_address      = 32'h0;
    memory_write_value  = 32'h0;
    memory_write_enable = 1'b0;
    switches            = 18'h0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state and cycle counter
    step(CYC,  0, 0, 1, 32'd0, 18'h0, 0, "rst_cycles");
    step(LED,  0, 0, 1, 32'd0, 18'h0, 0, "rst_led");
    step(SW,   0, 0, 1, 32'd0, 18'h0, 0, "rst_sw");
    step(CNT,  0, 0, 1, 32'd0, 18'h0, 0, "rst_count");
    step(STAT, 0, 0, 1, 32'd0, 18'h0, 0, "rst_status");
    step(CYC,  0, 0, 1, 32'd5, 18'h0, 0, "cycles_5");
    step(CYC,  32'h1234, 1, 1, 32'd6, 18'h0, 0, "cycles_wr");
    step(CYC,  0, 0, 1, 32'd0, 18'h0, 0, "cycles_clr");
    step(CYC,  0, 0, 1, 32'd1, 18'h0, 0, "cycles_inc");

    foreach (vecs[i])
      step(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].chk, vecs[i].exp_rd,
           vecs[i].exp_led, 1'b0, $sformatf("row%0d", i));

    // Switch synchroniser latency
    switches = 18'h00055;
    step(SW, 0, 0, 1, 32'h0,  18'h3FFFF, 0, "sw_lat0");
    step(SW, 0, 0, 1, 32'h0,  18'h3FFFF, 0, "sw_lat1");
    step(SW, 0, 0, 1, 32'h55, 18'h3FFFF, 0, "sw_lat2");

    // Timer countdown, expiry and clear
    step(CNT,  3, 1, 1, 32'd0, 18'h3FFFF, 0, "tmr_load3");
    step(CNT,  0, 0, 1, 32'd3, 18'h3FFFF, 0, "tmr_3");
    step(CNT,  0, 0, 1, 32'd2, 18'h3FFFF, 0, "tmr_2");
    step(CNT,  0, 0, 1, 32'd1, 18'h3FFFF, 0, "tmr_1");
    step(CNT,  0, 0, 1, 32'd0, 18'h3FFFF, 1, "tmr_0");
    step(STAT, 0, 0, 1, 32'd1, 18'h3FFFF, 1, "tmr_stat1");
    step(CNT,  0, 0, 1, 32'd0, 18'h3FFFF, 1, "tmr_hold0");
    step(STAT, 1, 1, 1, 32'd1, 18'h3FFFF, 1, "tmr_clr");
    step(STAT, 0, 0, 1, 32'd0, 18'h3FFFF, 0, "tmr_cleared");
    // Reload while counting, then load 0
    step(CNT,  4, 1, 1, 32'd0, 18'h3FFFF, 0, "tmr_load4");
    step(CNT,  0, 0, 1, 32'd4, 18'h3FFFF, 0, "tmr_4");
    step(CNT,  5, 1, 1, 32'd3, 18'h3FFFF, 0, "tmr_reload5");
    step(CNT,  0, 0, 1, 32'd5, 18'h3FFFF, 0, "tmr_5");
    step(CNT,  0, 1, 1, 32'd4, 18'h3FFFF, 0, "tmr_load0");
    step(CNT,  0, 0, 1, 32'd0, 18'h3FFFF, 0, "tmr_zero");
    step(STAT, 0, 0, 1, 32'd0, 18'h3FFFF, 0, "tmr_noexp");
    // Expiry coinciding with a status clear: set wins
    step(CNT,  2, 1, 1, 32'd0, 18'h3FFFF, 0, "tmr_load2");
    step(CNT,  0, 0, 1, 32'd2, 18'h3FFFF, 0, "tmr_2b");
    step(STAT, 1, 1, 1, 32'd0, 18'h3FFFF, 0, "tmr_clr_vs_set");
    step(STAT, 0, 0, 1, 32'd1, 18'h3FFFF, 1, "tmr_set_wins");

    // Reset in the middle of operation
    step(LED,  32'h15, 1, 1, 32'h0003FFFF, 18'h3FFFF, 1, "mid_led");
    step(CNT,  7, 1, 1, 32'd0, 18'h00015, 1, "mid_load7");
    step(CNT,  0, 0, 1, 32'd7, 18'h00015, 1, "mid_7");
    reset = 1'b1;
    step(CNT,  0, 0, 1, 32'd6, 18'h00015, 1, "mid_rst");
    reset = 1'b0;
    step(CNT,  0, 0, 1, 32'd0, 18'h0, 0, "post_count");
    step(32'h10, 0, 0, 1, 32'hDEADBEEF, 18'h0, 0, "post_ram");
    step(CYC,  0, 0, 1, 32'd2, 18'h0, 0, "post_cycles");
    step(SW,   0, 0, 1, 32'h55, 18'h0, 0, "post_sw");

`ifdef DMEM_ERROR_CAPTURE_EN
    step(32'h00020004, 0, 0, 1, 32'h0, 18'h0, 0, "err_acc1");
    step(32'h00030000, 0, 0, 1, 32'h0, 18'h0, 0, "err_acc2");
    step(32'hFFFF0014, 0, 0, 1, 32'h00020004, 18'h0, 0, "err_addr1");
    step(32'hFFFF0018, 0, 0, 1, 32'h1, 18'h0, 0, "err_stat1");
    step(32'hFFFF0018, 1, 1, 1, 32'h1, 18'h0, 0, "err_clr");
    step(32'hFFFF0018, 0, 0, 1, 32'h0, 18'h0, 0, "err_stat0");
    step(32'h00030000, 0, 0, 1, 32'h0, 18'h0, 0, "err_acc3");
    step(32'hFFFF0014, 0, 0, 1, 32'h00030000, 18'h0, 0, "err_addr2");
`else
    step(32'hFFFF0014, 32'hFFFFFFFF, 1, 1, 32'h0, 18'h0, 0, "noerr_wr14");
    step(32'hFFFF0014, 0, 0, 1, 32'h0, 18'h0, 0, "noerr_rd14");
    step(32'hFFFF0018, 0, 0, 1, 32'h0, 18'h0, 0, "noerr_rd18");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_memory_mmio.md
Name: data_memory_mmio

Overview:
Data-memory block directly downstream of the processor's memory stage. It consumes memory_address, memory_write_value and memory_write_enable, and returns memory_read_value in the same cycle. It is a word-addressed RAM plus a small memory-mapped peripheral page: LED register, synchronised switch input, free-running cycle counter and a one-shot down-timer. Processor-visible LED state comes from here, not from pipeline debug taps.

Parameters:
DEPTH_WORDS, 256, number of 32-bit RAM words (power of two, 16..4096)
MMIO_BASE, 32'hFFFF0000, base address of the peripheral page (64 KiB aligned)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
memory_address  input  32  byte address from the memory stage; bits [1:0] ignored
memory_write_value  input  32  store data
memory_write_enable  input  1  store strobe, sampled at posedge
memory_read_value  output  32  combinational read data
switches  input  18  asynchronous board switches
ledr  output  18  LED register bits [17:0]
timer_irq  output  1  level, equals the timer expired flag

Behaviour:
- Decode uses word address A = memory_address[31:2].
  - RAM hit: memory_address < DEPTH_WORDS*4. Index is memory_address[log2(DEPTH_WORDS)+1:2].
  - MMIO hit: memory_address[31:16] == MMIO_BASE[31:16]. Register selected by memory_address[15:2].
  - Anything else is unmapped: reads return 0, writes are ignored.
- Reads are zero latency (combinational from address and current state).
  - Read-during-write to the same location returns the pre-write value.
  - The new value is visible from the next cycle.
- Writes commit at the posedge when memory_write_enable=1.
- RAM contents are not reset; simulation initial value is don't-care.
- MMIO map (offsets from MMIO_BASE):
  - 0x00 LED: R/W. Bits [17:0] drive ledr. Upper bits read 0. Reset 0.
  - 0x04 SW: RO. Two-flop synchroniser output, zero-extended. Reset 0. A switch change is readable 2 clocks later. Writes ignored.
  - 0x08 CYCLES: 32-bit counter, +1 every clock, wraps 0xFFFFFFFF->0. Any write clears it to 0 (write wins over increment). Reset 0.
  - 0x0C TIMER_COUNT:
    - Write loads the count with the write value (load wins over decrement).
    - Otherwise, if count != 0, count decrements by 1 each clock.
    - Reads return the current count. Reset 0.
  - 0x10 TIMER_STATUS:
    - Bit0 = expired, sticky. It is set in the cycle count transitions 1->0 by decrement.
    - Writing 1 to bit0 clears it. Set wins over a simultaneous clear.
    - Loading 0 never sets expired.
    - Other bits read 0. Reset 0.
  - Other offsets read 0; writes are ignored.
- timer_irq = expired flag (registered, no combinational path from inputs).
- Reset mid-operation: all MMIO registers, synchroniser flops and timer return to 0 at the next posedge. RAM is retained.

Optional Feature:
Macro DMEM_ERROR_CAPTURE_EN.
- Defined:
  - The first unmapped access (read, or write with write-enable) after reset or clear latches its full byte address into ERR_ADDR (offset 0x14, RO).
  - It also sets ERR_STATUS bit0 (offset 0x18). Further errors do not overwrite ERR_ADDR while bit0=1.
  - "Access" means memory_address is unmapped in a cycle with write-enable=1, or any cycle in which it is unmapped. The bench drives address 0 when the stage is idle.
  - Writing 1 to ERR_STATUS bit0 clears it. Both registers reset to 0.
- Undefined: offsets 0x14 and 0x18 behave as unmapped. No capture logic is synthesised.

Test Plan:
1. RAM store/load: write 0xDEADBEEF to 0x00000010, then read 0x00000010 -> 0xDEADBEEF next cycle. Same-cycle read during the write -> old value. Read 0x00000013 -> 0xDEADBEEF (low bits ignored).
2. LED and switches: write 0x0003FFFF to 0xFFFF0000 -> ledr=18'h3FFFF next cycle. Set switches=18'h00055 -> 0xFFFF0004 reads 0 for 2 clocks, then 0x00000055.
3. Cycle counter: after reset, read 0xFFFF0008 on cycle 5 -> 5. Write any value -> reads 0 next cycle, 1 the cycle after.
4. Timer:
   - Write 3 to 0xFFFF000C -> count reads 3,2,1,0 on successive cycles. Expired/timer_irq rise with count 0.
   - Write 1 to 0xFFFF0010 -> irq low next cycle.
   - Reload with 5 while counting -> count reads 5.
   - Load 0 -> no expiry.
5. Unmapped and reset: read 0x00010000 with DEPTH_WORDS=256 -> 0; write there leaves all RAM and MMIO unchanged. Assert reset while the timer is at 7 and LED=0x15 -> next cycle count=0, ledr=0, irq=0, RAM word at 0x10 still 0xDEADBEEF.
6. (DMEM_ERROR_CAPTURE_EN) Access 0x00020004, then 0x00030000 -> ERR_ADDR=0x00020004, ERR_STATUS=1. Clear, then access 0x00030000 -> ERR_ADDR=0x00030000.
